csa_accum: RTL and testbench

CSA_ACCUM -- requirements
Module: csa_accum

---
 rtl/csa_accum.sv | 107 ++++++++++
 tb/tb_csa_accum.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_accum.sv
// Packet accumulator: operands are summed in carry-save form (no carry chain per beat),
// then a bit-serial ripple resolves the redundant pair into the final sum and overflow flag.
module csa_accum #(
    parameter int W    = 4,
    parameter int ACCW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ACCW-1:0] out_sum,
    output logic            out_ovf,
    output logic [1:0]      dbg_state
);

    // Handshake: a beat moves on a rising edge with in_valid && in_ready; a result
    // moves on a rising edge with out_valid && out_ready. Upstream holds while not ready.

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int IW = (ACCW > 1) ? $clog2(ACCW) : 1;

    state_t          state;
    logic [ACCW-1:0] s;
    logic [ACCW-1:0] c;
    logic [ACCW-1:0] res;
    logic            v;
    logic            cy;
    logic [IW-1:0]   idx;

    logic [ACCW-1:0] x;
    logic [ACCW-1:0] maj;
    logic            s_bit;
    logic            c_bit;
    logic            step_carry;

    always_comb begin
        x          = {{(ACCW - W){1'b0}}, in_data};
        maj        = (s & c) | (s & x) | (c & x);
        s_bit      = s[idx];
        c_bit      = c[idx];
        step_carry = (s_bit & c_bit) | (s_bit & cy) | (c_bit & cy);
    end

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign out_sum   = res;
    assign out_ovf   = v;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ACCUM;
            s     <= '0;
            c     <= '0;
            res   <= '0;
            v     <= 1'b0;
            cy    <= 1'b0;
            idx   <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid && in_ready) begin
                        s <= s ^ c ^ x;
                        // The top majority bit has weight 2^ACCW and is lost to the vector.
                        c <= {maj[ACCW-2:0], 1'b0};
                        v <= v | maj[ACCW-1];
                        if (in_last) begin
                            state <= RESOLVE;
                            idx   <= '0;
                            cy    <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    res[idx] <= s_bit ^ c_bit ^ cy;
                    cy       <= step_carry;
                    if (idx == IW'(ACCW - 1)) begin
                        state <= DONE;
                        v     <= v | step_carry;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= ACCUM;
                        s     <= '0;
                        c     <= '0;
                        res   <= '0;
                        v     <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accum.sv
// Bench for csa_accum: directed corner cases plus random packets scored against
// an arithmetic model (plain integer sum, modulo and threshold).
module tb_csa_accum;

    localparam int W    = 4;
    localparam int ACCW = 8;
    localparam int MODV = 1 << ACCW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_data;
    logic            in_last;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [ACCW-1:0] out_sum;
    logic            out_ovf;
    logic [1:0]      dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int rx_mode  = 2;   // 0: always ready, 1: random ready, 2: hold low
    bit abort    = 1'b0;

    logic [ACCW:0] exp_q[$];   // {ovf, sum}
    int beats[64];

    csa_accum #(.W(W), .ACCW(ACCW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf),
        .dbg_state(dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // consumer side ready pattern
    always @(posedge clk) begin
        #1;
        case (rx_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // scoreboard: every output handshake is compared against the model queue
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                logic [ACCW:0] e;
                e = exp_q.pop_front();
                check("out_sum", 32'(out_sum), 32'(e[ACCW-1:0]));
                check("out_ovf", 32'(out_ovf), 32'(e[ACCW]));
            end
        end
    end

    // driver tasks
    task automatic send_beat(input int d, input logic last, input bit gaps);
        int budget;
        if (gaps) begin
            while ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_data  = W'($urandom_range(0, (1 << W) - 1));
                in_last  = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = W'(d);
        in_last  = last;
        budget   = 0;
        forever begin
            if (in_ready) begin
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            budget++;
            if (budget > 200) begin
                check("in_ready_timeout", 32'd1, 32'd0);
                abort = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_packet(input int n, input bit gaps, input bit expect_out);
        int total;
        total = 0;
        for (int i = 0; i < n; i++) total += beats[i];
        if (expect_out) exp_q.push_back({(total >= MODV), ACCW'(total % MODV)});
        for (int i = 0; i < n; i++) begin
            if (abort) break;
            send_beat(beats[i], (i == n - 1), gaps);
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 500) begin
            @(posedge clk); #1;
            budget++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic watch_no_valid(input string tag, input int cycles);
        int cnt;
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            if (out_valid) cnt++;
            @(posedge clk); #1;
        end
        check(tag, 32'(cnt), 32'd0);
    endtask

    initial begin
        int lat;
        int n;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        rst_n = 1'b1;

        // 15,15,15 with latency measurement and a stalled consumer
        rx_mode = 2;
        beats[0] = 15; beats[1] = 15; beats[2] = 15;
        send_packet(3, 1'b0, 1'b1);
        check("resolve_in_ready", 32'(in_ready), 32'd0);
        wait_done(lat);
        check("latency", 32'(lat), 32'(ACCW));
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_sum", 32'(out_sum), 32'd45);
            check("hold_ovf", 32'(out_ovf), 32'd0);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        rx_mode = 0;
        drain();

        beats[0] = 3; beats[1] = 4;
        send_packet(2, 1'b0, 1'b1);
        drain();

        for (int i = 0; i < 18; i++) beats[i] = 15;
        send_packet(17, 1'b0, 1'b1);
        drain();
        send_packet(18, 1'b0, 1'b1);
        drain();

        beats[0] = 0;
        send_packet(1, 1'b0, 1'b1);
        drain();
        beats[0] = 9;
        send_packet(1, 1'b0, 1'b1);
        drain();

        // reset at RESOLVE step 3
        beats[0] = 7;
        send_packet(1, 1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        pulse_reset();
        check("rstres_in_ready", 32'(in_ready), 32'd1);
        check("rstres_out_valid", 32'(out_valid), 32'd0);
        check("rstres_out_sum", 32'(out_sum), 32'd0);
        watch_no_valid("rstres_no_pulse", ACCW + 4);
        beats[0] = 1;
        send_packet(1, 1'b0, 1'b1);
        drain();

        // reset while holding a completed result
        rx_mode = 2;
        beats[0] = 15; beats[1] = 15;
        for (int i = 2; i < 20; i++) beats[i] = 15;
        send_packet(20, 1'b0, 1'b0);
        wait_done(lat);
        check("rstdone_reached", 32'(out_valid), 32'd1);
        check("rstdone_pre_ovf", 32'(out_ovf), 32'd1);
        pulse_reset();
        check("rstdone_out_valid", 32'(out_valid), 32'd0);
        check("rstdone_out_ovf", 32'(out_ovf), 32'd0);
        check("rstdone_out_sum", 32'(out_sum), 32'd0);
        check("rstdone_in_ready", 32'(in_ready), 32'd1);
        rx_mode = 0;
        watch_no_valid("rstdone_no_pulse", ACCW + 4);

        // reset mid-packet, then a clean packet
        send_beat(15, 1'b0, 1'b0);
        send_beat(15, 1'b0, 1'b0);
        pulse_reset();
        beats[0] = 3; beats[1] = 4;
        send_packet(2, 1'b0, 1'b1);
        drain();

        // random packets with gaps on both sides
        rx_mode = 1;
        for (int p = 0; p < 1000; p++) begin
            if (abort) break;
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) beats[i] = $urandom_range(0, (1 << W) - 1);
            send_packet(n, 1'b1, 1'b1);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
